// File: rtl/dp_ram_param.sv
// Dual-port RAM with one shared array. Port reads are registered. A sweep
// engine zeroes the whole array after reset release and on each clr request.
module dp_ram_param #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 8,
    parameter int WRITE_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [WIDTH-1:0]  din_a,
    input  logic              en_a,
    input  logic              we_a,
    output logic [WIDTH-1:0]  dout_a,
    output logic              valid_a,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [WIDTH-1:0]  din_b,
    input  logic              en_b,
    input  logic              we_b,
    output logic [WIDTH-1:0]  dout_b,
    output logic              valid_b,
    input  logic              clr,
    output logic              busy,
    output logic              collision
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic wr_a, rd_a, wr_b, rd_b, same_addr;

    assign busy      = (state == SWEEP);
    assign wr_a      = en_a &  we_a & ~busy;
    assign rd_a      = en_a & ~we_a & ~busy;
    assign wr_b      = en_b &  we_b & ~busy;
    assign rd_b      = en_b & ~we_b & ~busy;
    assign same_addr = (add_a == add_b);

    // Reset parks the engine in SWEEP at address 0. The sweep therefore
    // starts on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr <= '0;
                    if (clr) state <= SWEEP;
                end
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset. While rst is held, the engine keeps writing zero
    // to address 0, and the restarted sweep zeroes that address anyway.
    // Port A is written last so that it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else begin
            if (wr_b) mem[add_b] <= din_b;
            if (wr_a) mem[add_a] <= din_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a    <= '0;
            dout_b    <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_a   <= rd_a;
            valid_b   <= rd_b;
            collision <= wr_a & wr_b & same_addr;
            // Write-first bypasses the other port's write data.
            // Read-first sees the array value from before this edge.
            if (rd_a)
                dout_a <= (WRITE_FIRST != 0 && wr_b && same_addr) ? din_b : mem[add_a];
            if (rd_b)
                dout_b <= (WRITE_FIRST != 0 && wr_a && same_addr) ? din_a : mem[add_b];
        end
    end
endmodule
